// File: rtl/dict_stream_scheduler.sv
// Sequencing controller for the dictionary decompressor: buffers codebook indices
// in a small FIFO, loads them back-to-back and re-exports the serial bitstream.
module dict_stream_scheduler #(
    parameter int CHUNK_SIZE    = 8,
    parameter int CODEBOOK_SIZE = 16,
    parameter int INDEX_BITS    = $clog2(CODEBOOK_SIZE),
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] in_index,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [INDEX_BITS-1:0] dec_index,
    output logic                  dec_load,
    output logic                  dec_shift_enable,
    input  logic                  dec_serial_out,
    input  logic                  dec_shift_done,
    output logic                  out_bit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_chunk_end,
    output logic                  out_frame_end,
    output logic [15:0]           chunk_count,
    output logic                  sync_err,
    output logic                  busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BIT_W = $clog2(CHUNK_SIZE);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHUNK_SIZE - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W + 1)'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    // ------------------------------------------------------------------
    // Index FIFO: entries are {last, index}; wrap bit separates full/empty.
    // ------------------------------------------------------------------
    logic [INDEX_BITS:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic [INDEX_BITS:0] head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign in_ready   = !fifo_full && !rst;
    assign push       = in_valid && in_ready;
    assign head       = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign dec_index  = head[INDEX_BITS-1:0];
    assign wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    assign rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    // NOTE: storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {in_last, in_index};
        end
    end

    // ------------------------------------------------------------------
    // Chunk sequencing FSM
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
    logic             frame_last_q, frame_last_d;
    logic [15:0]      chunk_count_q, chunk_count_d;
    logic             sync_err_q, sync_err_d;
    logic             final_bit;

    assign final_bit = (bit_idx_q == LAST_BIT);

    // NOTE: sequential state uses non-blocking assignments only; all next-state
    // values are computed in the combinational process below.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_idx_q     <= '0;
            frame_last_q  <= 1'b0;
            chunk_count_q <= '0;
            sync_err_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            bit_idx_q     <= bit_idx_d;
            frame_last_q  <= frame_last_d;
            chunk_count_q <= chunk_count_d;
            sync_err_q    <= sync_err_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d          = state_q;
        bit_idx_d        = bit_idx_q;
        frame_last_d     = frame_last_q;
        chunk_count_d    = chunk_count_q;
        pop              = 1'b0;
        dec_load         = 1'b0;
        dec_shift_enable = 1'b0;
        out_valid        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    dec_load      = 1'b1;
                    pop           = 1'b1;
                    frame_last_d  = head[INDEX_BITS];
                    bit_idx_d     = '0;
                    chunk_count_d = chunk_count_q + 16'd1;
                    state_d       = SHIFT;
                end
            end
            SHIFT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (!final_bit) begin
                        dec_shift_enable = 1'b1;
                        bit_idx_d        = bit_idx_q + BIT_ONE;
                    end else if (!fifo_empty) begin
                        // Reload on the last bit so the next MSB follows with no bubble.
                        dec_load      = 1'b1;
                        pop           = 1'b1;
                        frame_last_d  = head[INDEX_BITS];
                        bit_idx_d     = '0;
                        chunk_count_d = chunk_count_q + 16'd1;
                    end else begin
                        dec_shift_enable = 1'b1;
                        state_d          = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        sync_err_d = sync_err_q || ((state_q == SHIFT) && dec_shift_done);
    end

    assign out_bit       = (state_q == SHIFT) && dec_serial_out;
    assign out_chunk_end = (state_q == SHIFT) && final_bit;
    assign out_frame_end = out_chunk_end && frame_last_q;
    assign chunk_count   = chunk_count_q;
    assign sync_err      = sync_err_q;
    assign busy          = !fifo_empty || (state_q == SHIFT);

    // ------------------------------------------------------------------
    // Protocol invariants
    // ------------------------------------------------------------------
    a_load_shift_exclusive : assert property (
        @(posedge clk) disable iff (rst) !(dec_load && dec_shift_enable));

    a_no_overflow : assert property (
        @(posedge clk) disable iff (rst) fifo_full |-> !push);

    a_hold_under_backpressure : assert property (
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |-> (!dec_shift_enable && !dec_load));

endmodule

// File: tb/tb_dict_stream_scheduler.sv
// Directed bench for dict_stream_scheduler with a behavioural decompressor model
// holding a fixed codebook; expected streams are hand-derived from that codebook.
module tb_dict_stream_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  in_index;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  dec_index;
    logic        dec_load;
    logic        dec_shift_enable;
    logic        dec_serial_out;
    logic        dec_shift_done;
    logic        out_bit;
    logic        out_valid;
    logic        out_ready;
    logic        out_chunk_end;
    logic        out_frame_end;
    logic [15:0] chunk_count;
    logic        sync_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    dict_stream_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .in_index         (in_index),
        .in_last          (in_last),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .dec_index        (dec_index),
        .dec_load         (dec_load),
        .dec_shift_enable (dec_shift_enable),
        .dec_serial_out   (dec_serial_out),
        .dec_shift_done   (dec_shift_done),
        .out_bit          (out_bit),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_chunk_end    (out_chunk_end),
        .out_frame_end    (out_frame_end),
        .chunk_count      (chunk_count),
        .sync_err         (sync_err),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decompressor model: load copies a codebook entry, shift moves it left, MSB first.
    logic [7:0] cb [16];
    logic [7:0] sreg;
    logic [3:0] scnt;
    logic       model_done;
    logic       force_done;

    initial begin
        cb[0]  = 8'h00; cb[1]  = 8'h81; cb[2]  = 8'h99; cb[3]  = 8'hE7;
        cb[4]  = 8'hFF; cb[5]  = 8'hA5; cb[6]  = 8'h5A; cb[7]  = 8'hC3;
        cb[8]  = 8'h0F; cb[9]  = 8'hF0; cb[10] = 8'h55; cb[11] = 8'hAA;
        cb[12] = 8'h33; cb[13] = 8'hCC; cb[14] = 8'h18; cb[15] = 8'h1C;
    end

    always @(posedge clk) begin
        if (rst) begin
            sreg       <= 8'h00;
            scnt       <= 4'd0;
            model_done <= 1'b0;
        end else if (dec_load) begin
            sreg       <= cb[dec_index];
            scnt       <= 4'd0;
            model_done <= 1'b0;
        end else if (dec_shift_enable) begin
            sreg       <= sreg << 1;
            scnt       <= scnt + 4'd1;
            model_done <= (scnt == 4'd7);
        end else begin
            model_done <= 1'b0;
        end
    end

    assign dec_serial_out = sreg[7];
    assign dec_shift_done = model_done | force_done;

    typedef struct packed {
        logic b;
        logic ce;
        logic fe;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic expect_chunk(input logic [7:0] val, input logic last);
        exp_t e;
        for (int i = 7; i >= 0; i--) begin
            e.b  = val[i];
            e.ce = (i == 0);
            e.fe = (i == 0) && last;
            exp_q.push_back(e);
        end
    endtask

    task automatic expect_bit(input logic b);
        exp_t e;
        e.b  = b;
        e.ce = 1'b0;
        e.fe = 1'b0;
        exp_q.push_back(e);
    endtask

    // Stream scoreboard, run once per cycle at the falling edge.
    task automatic mon();
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_bit", 32'(out_valid), 0);
            end else begin
                e = exp_q.pop_front();
                check("out_bit", 32'(out_bit), 32'(e.b));
                check("chunk_end", 32'(out_chunk_end), 32'(e.ce));
                check("frame_end", 32'(out_frame_end), 32'(e.fe));
            end
        end
    endtask

    task automatic wait_neg();
        @(negedge clk);
        mon();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        wait_neg();
        to_pos();
    endtask

    task automatic push(input logic [3:0] idx, input logic last);
        in_index = idx;
        in_last  = last;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy || out_valid) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 0);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        rst        = 1'b1;
        in_index   = 4'd0;
        in_last    = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        force_done = 1'b0;

        // Reset
        to_pos();
        to_pos();
        wait_neg();
        check("rst_in_ready", 32'(in_ready), 0);
        to_pos();
        rst = 1'b0;
        wait_neg();
        check("rst_in_ready_rel", 32'(in_ready), 1);
        check("rst_load", 32'(dec_load), 0);
        check("rst_shift", 32'(dec_shift_enable), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_chunk_end", 32'(out_chunk_end), 0);
        check("rst_count", 32'(chunk_count), 0);
        check("rst_sync_err", 32'(sync_err), 0);
        check("rst_busy", 32'(busy), 0);
        to_pos();

        // Single chunk: index 2 -> 1,0,0,1,1,0,0,1
        expect_chunk(8'h99, 1'b0);
        push(4'd2, 1'b0);
        wait_neg();
        check("t1_load", 32'(dec_load), 1);
        check("t1_index", 32'(dec_index), 2);
        check("t1_valid_pre", 32'(out_valid), 0);
        check("t1_busy", 32'(busy), 1);
        to_pos();
        wait_neg();
        check("t1_load_pulse", 32'(dec_load), 0);
        check("t1_shift", 32'(dec_shift_enable), 1);
        to_pos();
        wait_idle("t1", 20);
        check("t1_count", 32'(chunk_count), 1);
        check("t1_valid_post", 32'(out_valid), 0);

        // Back-to-back: 4 then 0 -> 16 consecutive bits
        expect_chunk(8'hFF, 1'b0);
        expect_chunk(8'h00, 1'b0);
        push(4'd4, 1'b0);
        push(4'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            wait_neg();
            check("t2_valid", 32'(out_valid), 1);
            if (i == 7) begin
                check("t2_reload", 32'(dec_load), 1);
                check("t2_reload_shift", 32'(dec_shift_enable), 0);
            end
            to_pos();
        end
        wait_neg();
        check("t2_valid_end", 32'(out_valid), 0);
        to_pos();
        wait_idle("t2", 20);
        check("t2_count", 32'(chunk_count), 3);

        // Backpressure: index 10, hold for 3 cycles after two bits
        expect_chunk(8'h55, 1'b0);
        push(4'd10, 1'b0);
        step();
        step();
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_neg();
            check("t3_hold_bit", 32'(out_bit), 0);
            check("t3_hold_shift", 32'(dec_shift_enable), 0);
            check("t3_hold_valid", 32'(out_valid), 1);
            to_pos();
        end
        out_ready = 1'b1;
        wait_idle("t3", 20);

        // FIFO full: one resident + four queued
        expect_chunk(8'h81, 1'b0);
        expect_chunk(8'h99, 1'b0);
        expect_chunk(8'hE7, 1'b0);
        expect_chunk(8'hFF, 1'b0);
        expect_chunk(8'hA5, 1'b0);
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_index = 4'(i);
            in_valid = 1'b1;
            wait_neg();
            check($sformatf("t4_in_ready_%0d", i), 32'(in_ready), (i <= 5) ? 1 : 0);
            to_pos();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_neg();
            check("t4_still_full", 32'(in_ready), 0);
            to_pos();
        end
        wait_neg();
        check("t4_ready_after_pop", 32'(in_ready), 1);
        to_pos();
        wait_idle("t4", 60);
        check("t4_count", 32'(chunk_count), 9);

        // Frame marker: 9 (last=0), 8 (last=1)
        expect_chunk(8'hF0, 1'b0);
        expect_chunk(8'h0F, 1'b1);
        push(4'd9, 1'b0);
        push(4'd8, 1'b1);
        wait_idle("t5", 30);
        check("t5_count", 32'(chunk_count), 11);
        check("t5_sync_err", 32'(sync_err), 0);

        // Reset mid-chunk of index 11, then index 15
        expect_bit(1'b1);
        expect_bit(1'b0);
        expect_bit(1'b1);
        push(4'd11, 1'b0);
        step();
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_neg();
        check("t6_load", 32'(dec_load), 0);
        check("t6_shift", 32'(dec_shift_enable), 0);
        check("t6_valid", 32'(out_valid), 0);
        check("t6_chunk_end", 32'(out_chunk_end), 0);
        check("t6_frame_end", 32'(out_frame_end), 0);
        check("t6_count", 32'(chunk_count), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_in_ready", 32'(in_ready), 1);
        check("t6_partial", exp_q.size(), 0);
        to_pos();
        expect_chunk(8'h1C, 1'b0);
        push(4'd15, 1'b0);
        wait_idle("t6", 20);
        check("t6_count_after", 32'(chunk_count), 1);
        check("t6_sync_err", 32'(sync_err), 0);

        // Sync error: shift_done while shifting, sticky afterwards
        expect_chunk(8'h00, 1'b0);
        push(4'd0, 1'b0);
        step();
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        wait_neg();
        check("t7_sync_err", 32'(sync_err), 1);
        to_pos();
        wait_idle("t7", 20);
        check("t7_sticky", 32'(sync_err), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
